// File: rtl/conv_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the convolution tile sequencer.
// Pure declarations: no logic, no latency, no flow control.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_WRITE   = 3'd5,
        ST_RELEASE = 3'd6
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = 1; v < value; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ntiles(input int lenx, input int lenf, input int p);
        return (lenx - lenf + 1 + p - 1) / p;
    endfunction

endpackage

// File: rtl/conv_lane_addr_gen.sv
// Per-lane x address clamp and lane-valid compare; purely combinational, zero latency.
// No flow control: outputs follow base/tap within the same cycle.
module conv_lane_addr_gen #(
    parameter int ADDRX = 5,
    parameter int LENX  = 32,
    parameter int SIZE  = 24,
    parameter int P     = 8
) (
    input  logic [ADDRX-1:0]          base_i,
    input  logic [ADDRX-1:0]          tap_i,
    output logic [P-1:0][ADDRX-1:0]   addr_o,
    output logic [P-1:0]              mask_o
);

    localparam logic [ADDRX:0] LAST_X = (ADDRX+1)'(LENX - 1);
    localparam logic [ADDRX:0] SIZE_W = (ADDRX+1)'(SIZE);

    for (genvar i = 0; i < P; i++) begin : g_lane
        logic [ADDRX:0] pos;
        logic [ADDRX:0] sum;

        // One extra bit so the last tile's overshoot is clamped rather than wrapped.
        assign pos = {1'b0, base_i} + (ADDRX+1)'(i);
        assign sum = pos + {1'b0, tap_i};

        assign addr_o[i] = (sum > LAST_X) ? LAST_X[ADDRX-1:0] : sum[ADDRX-1:0];
        assign mask_o[i] = (pos < SIZE_W);
    end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks the output vector in P-lane tiles once x is loaded; LENF+4 cycles per tile.
// Stalls only in WAIT while op_free is low; a started tile always completes.
module conv_tile_scheduler
    import conv_ctrl_pkg::*;
#(
    parameter int ADDRX = 5,
    parameter int ADDRF = 4,
    parameter int LENX  = 32,
    parameter int LENF  = 9,
    parameter int P     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x_loaded,
    input  logic                     op_free,
    output logic [P-1:0][ADDRX-1:0]  m_addr_read_x,
    output logic [ADDRF-1:0]         m_addr_read_f,
    output logic                     clr_acc,
    output logic                     en_acc,
    output logic                     valid_op,
    output logic [ADDRX-1:0]         start_addr,
    output logic [P-1:0]             lane_mask,
    output logic                     x_release,
    output logic                     busy
);

    localparam int SIZE = LENX - LENF + 1;
    localparam int NT   = ntiles(LENX, LENF, P);
    localparam int KW   = (clog2(NT) < 1) ? 1 : clog2(NT);
    localparam int JW   = (clog2(LENF) < 1) ? 1 : clog2(LENF);

    localparam logic [KW-1:0] K_LAST = KW'(NT - 1);
    localparam logic [JW-1:0] J_LAST = JW'(LENF - 1);

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [JW-1:0]            j_q, j_d;
    logic                     en_q;
    logic [ADDRX-1:0]         base;
    logic [P-1:0][ADDRX-1:0]  lane_addr;
    logic [P-1:0]             lane_valid;

    assign base = ADDRX'(int'(k_q) * P);

    conv_lane_addr_gen #(
        .ADDRX (ADDRX),
        .LENX  (LENX),
        .SIZE  (SIZE),
        .P     (P)
    ) u_lane_addr (
        .base_i (base),
        .tap_i  (ADDRX'(j_q)),
        .addr_o (lane_addr),
        .mask_o (lane_valid)
    );

    // en_q tracks "last cycle was RUN" to line up with the 1-cycle memory read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            en_q    <= (state_q == ST_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (x_loaded) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (op_free) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                j_d     = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                if (k_q == K_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_addr_read_x = '0;
        m_addr_read_f = '0;
        clr_acc       = 1'b0;
        en_acc        = en_q;
        valid_op      = 1'b0;
        start_addr    = '0;
        lane_mask     = '0;
        x_release     = 1'b0;
        busy          = (state_q != ST_IDLE);
        case (state_q)
            ST_CLEAR: clr_acc = 1'b1;
            ST_RUN: begin
                m_addr_read_x = lane_addr;
                m_addr_read_f = ADDRF'(j_q);
            end
            ST_WRITE: begin
                valid_op   = 1'b1;
                start_addr = base;
                lane_mask  = lane_valid;
            end
            ST_RELEASE: x_release = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Three scheduler instances (default, short tail tile, single output) checked every cycle
// against a tile-offset reference model under directed and random x_loaded/op_free/reset.
module tb_conv_tile_scheduler;

    localparam int NI = 3;
    localparam int P  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x_loaded = 1'b0;
    logic op_free = 1'b0;

    logic [P-1:0][4:0] mx   [NI];
    logic [3:0]        mf   [NI];
    logic              clr  [NI];
    logic              en   [NI];
    logic              vld  [NI];
    logic [4:0]        sa   [NI];
    logic [P-1:0]      lm   [NI];
    logic              xrel [NI];
    logic              bsy  [NI];

    int lenx_t [NI] = '{32, 30, 9};
    int lenf_t [NI] = '{9, 9, 9};

    // Reference model: where each instance is within its vector, as a tile offset.
    bit m_busy [NI];
    bit m_wait [NI];
    bit m_rel  [NI];
    int m_k    [NI];
    int m_t    [NI];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int phase = 0;
    int c0 = 0;
    int en_cnt [NI];
    int rel_cyc [NI];
    int valid0_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_tile_scheduler #(.ADDRX(5), .ADDRF(4), .LENX(32), .LENF(9), .P(8)) u_dut0 (
        .clk(clk), .reset(reset), .x_loaded(x_loaded), .op_free(op_free),
        .m_addr_read_x(mx[0]), .m_addr_read_f(mf[0]), .clr_acc(clr[0]), .en_acc(en[0]),
        .valid_op(vld[0]), .start_addr(sa[0]), .lane_mask(lm[0]), .x_release(xrel[0]),
        .busy(bsy[0])
    );

    conv_tile_scheduler #(.ADDRX(5), .ADDRF(4), .LENX(30), .LENF(9), .P(8)) u_dut1 (
        .clk(clk), .reset(reset), .x_loaded(x_loaded), .op_free(op_free),
        .m_addr_read_x(mx[1]), .m_addr_read_f(mf[1]), .clr_acc(clr[1]), .en_acc(en[1]),
        .valid_op(vld[1]), .start_addr(sa[1]), .lane_mask(lm[1]), .x_release(xrel[1]),
        .busy(bsy[1])
    );

    conv_tile_scheduler #(.ADDRX(5), .ADDRF(4), .LENX(9), .LENF(9), .P(8)) u_dut2 (
        .clk(clk), .reset(reset), .x_loaded(x_loaded), .op_free(op_free),
        .m_addr_read_x(mx[2]), .m_addr_read_f(mf[2]), .clr_acc(clr[2]), .en_acc(en[2]),
        .valid_op(vld[2]), .start_addr(sa[2]), .lane_mask(lm[2]), .x_release(xrel[2]),
        .busy(bsy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int model_ntiles(input int n);
        return (lenx_t[n] - lenf_t[n] + 1 + P - 1) / P;
    endfunction

    function automatic int model_mask(input int n);
        int size, base, m;
        size = lenx_t[n] - lenf_t[n] + 1;
        base = m_k[n] * P;
        m = 0;
        for (int i = 0; i < P; i++) begin
            if (base + i < size) m = m | (1 << i);
        end
        return m;
    endfunction

    task automatic check_inst(input int n);
        bit in_tile, run, wr;
        int t, lf, base, a;
        in_tile = m_busy[n] && !m_wait[n] && !m_rel[n];
        t    = m_t[n];
        lf   = lenf_t[n];
        base = m_k[n] * P;
        run  = in_tile && (t >= 1) && (t <= lf);
        wr   = in_tile && (t == lf + 2);
        check($sformatf("busy%0d", n), 32'(bsy[n]), 32'(m_busy[n]));
        check($sformatf("clr_acc%0d", n), 32'(clr[n]), 32'(in_tile && t == 0));
        check($sformatf("en_acc%0d", n), 32'(en[n]), 32'(in_tile && t >= 2 && t <= lf + 1));
        check($sformatf("valid_op%0d", n), 32'(vld[n]), 32'(wr));
        check($sformatf("x_release%0d", n), 32'(xrel[n]), 32'(m_rel[n]));
        check($sformatf("addr_f%0d", n), 32'(mf[n]), run ? t - 1 : 0);
        check($sformatf("start_addr%0d", n), 32'(sa[n]), wr ? base : 0);
        check($sformatf("lane_mask%0d", n), 32'(lm[n]), wr ? model_mask(n) : 0);
        for (int i = 0; i < P; i++) begin
            a = base + i + t - 1;
            if (a > lenx_t[n] - 1) a = lenx_t[n] - 1;
            check($sformatf("addr_x%0d_l%0d", n, i), 32'(mx[n][i]), run ? a : 0);
        end
    endtask

    task automatic step_model(input int n);
        if (reset) begin
            m_busy[n] = 0; m_wait[n] = 0; m_rel[n] = 0; m_k[n] = 0; m_t[n] = 0;
        end else if (!m_busy[n]) begin
            if (x_loaded) begin
                m_busy[n] = 1; m_wait[n] = 1; m_k[n] = 0;
            end
        end else if (m_rel[n]) begin
            m_busy[n] = 0; m_rel[n] = 0;
        end else if (m_wait[n]) begin
            if (op_free) begin
                m_wait[n] = 0; m_t[n] = 0;
            end
        end else if (m_t[n] == lenf_t[n] + 2) begin
            if (m_k[n] < model_ntiles(n) - 1) begin
                m_k[n]++; m_wait[n] = 1;
            end else begin
                m_rel[n] = 1;
            end
        end else begin
            m_t[n]++;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int n = 0; n < NI; n++) check_inst(n);
            if (vld[0]) valid0_q.push_back(cyc);
            if (phase == 1) begin
                for (int n = 0; n < NI; n++) begin
                    if (rel_cyc[n] < 0 && en[n]) en_cnt[n]++;
                    if (rel_cyc[n] < 0 && xrel[n]) rel_cyc[n] = cyc;
                end
            end
            for (int n = 0; n < NI; n++) step_model(n);
        end
    end

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        x_loaded = 1'b0;
        op_free = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < NI; n++) begin
            m_busy[n] = 0; m_wait[n] = 0; m_rel[n] = 0; m_k[n] = 0; m_t[n] = 0;
            en_cnt[n] = 0; rel_cyc[n] = -1;
        end
        @(posedge clk);
        #1 mon_en = 1'b1;
        do_reset(2);
        @(posedge clk);

        // Full vector with op_free held high, cycle 0 = IDLE with x_loaded.
        #1 phase = 1;
        x_loaded = 1'b1;
        op_free = 1'b1;
        c0 = cyc;
        valid0_q.delete();
        repeat (60) @(posedge clk);
        #1 phase = 0;
        check("rel_cycle0", 32'(rel_cyc[0] - c0), 40);
        check("rel_cycle1", 32'(rel_cyc[1] - c0), 40);
        check("rel_cycle2", 32'(rel_cyc[2] - c0), 14);
        check("en_total0", 32'(en_cnt[0]), 27);
        check("en_total2", 32'(en_cnt[2]), 9);
        check("valid_cnt0", 32'(valid0_q.size() >= 3), 1);
        if (valid0_q.size() >= 3) begin
            check("valid_t0", 32'(valid0_q[0] - c0), 13);
            check("valid_t1", 32'(valid0_q[1] - c0), 26);
            check("valid_t2", 32'(valid0_q[2] - c0), 39);
        end

        // Backpressure: op_free low for the 10 cycles after the first WRITE.
        do_reset(2);
        @(posedge clk);
        #1 x_loaded = 1'b1;
        op_free = 1'b1;
        c0 = cyc;
        valid0_q.delete();
        repeat (14) @(posedge clk);
        #1 op_free = 1'b0;
        repeat (10) @(posedge clk);
        #1 op_free = 1'b1;
        repeat (30) @(posedge clk);
        #1 check("bp_valid_cnt", 32'(valid0_q.size() >= 2), 1);
        if (valid0_q.size() >= 2) begin
            check("bp_slip", 32'(valid0_q[1] - valid0_q[0]), 23);
        end

        // Reset during tile 1 RUN j=4, then restart with x_loaded still high.
        do_reset(2);
        @(posedge clk);
        #1 x_loaded = 1'b1;
        op_free = 1'b1;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        valid0_q.delete();
        repeat (20) @(posedge clk);
        #1 check("restart_valid", 32'(valid0_q.size()), 1);

        // Random traffic with occasional protocol violations and resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1 op_free = ($urandom_range(0, 3) != 0);
            x_loaded = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
